// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first) with a single-entry valid/ready holding register.
// The line is resynchronised, each frame is sampled at bit centres, and good bytes are
// offered to the consumer; stop-bit and overrun problems are flagged with one-cycle pulses.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overrun_o
);

   // Reject bit periods too short for the half-bit start check to mean anything.
   if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx: CLKS_PER_BIT must be >= 4");
   end

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam int unsigned IDX_W = 3;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [7:0]       shift;
   logic [7:0]       shift_nxt;
   logic             rx_meta;
   logic             rx_s;

   logic [7:0]       data_nxt;
   logic             valid_nxt;
   logic             frame_err_nxt;
   logic             overrun_nxt;

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         rx_meta <= 1'b0;
         rx_s    <= 1'b0;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   // Next-state, counters, shift register and output next-values for the frame FSM.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      shift_nxt     = shift;
      data_nxt      = data_o;
      valid_nxt     = valid_o & ~ready_i;
      frame_err_nxt = 1'b0;
      overrun_nxt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nxt = S_START;
               cnt_nxt   = '0;
            end
         end

         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt = S_DATA;
                  idx_nxt   = '0;
               end else begin
                  // Line came back high before mid start bit: treat as a glitch.
                  state_nxt = S_IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt        = '0;
               shift_nxt[idx] = rx_s;
               if (idx == IDX_LAST) begin
                  state_nxt = S_STOP;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = S_IDLE;
                  // Load when the holding register is free or being drained this cycle.
                  if (!valid_o || ready_i) begin
                     data_nxt  = shift;
                     valid_nxt = 1'b1;
                  end else begin
                     overrun_nxt = 1'b1;
                  end
               end else begin
                  state_nxt     = S_WAIT_IDLE;
                  frame_err_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_WAIT_IDLE: begin
            // Hold off until the line is seen idle, so a break or a stuck-low line
            // never looks like a start bit.
            if (rx_s) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_WAIT_IDLE;
         end
      endcase
   end

   // FSM state, bit timing and shift register; busy mirrors the next state.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state  <= S_WAIT_IDLE;
         cnt    <= '0;
         idx    <= '0;
         shift  <= '0;
         busy_o <= 1'b1;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         shift  <= shift_nxt;
         busy_o <= (state_nxt != S_IDLE);
      end
   end

   // Holding register and status pulses.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         data_o      <= data_nxt;
         valid_o     <= valid_nxt;
         frame_err_o <= frame_err_nxt;
         overrun_o   <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bit-banged frames into uart_rx, checked every cycle against a
// transaction-level model of the holding register and frame outcomes.
module tb_uart_rx;

   localparam int unsigned C   = 16;
   localparam int unsigned H   = C / 2;
   localparam longint      LAT = longint'(3 + H + 9 * C);

   logic       clk     = 1'b0;
   logic       reset_i = 1'b1;
   logic       rx_i    = 1'b1;
   logic       ready_i = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       busy_o;
   logic       frame_err_o;
   logic       overrun_o;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .busy_o      (busy_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Expected frame outcomes: nominal delivery cycle, byte, stop bit level.
   typedef struct {
      longint     d;
      logic [7:0] b;
      bit         ok;
   } ev_t;
   ev_t evq[$];

   typedef enum int {K_DEL, K_OVR, K_FERR} kind_t;

   // Model of the holding register.
   bit         m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;

   // Per-window observations.
   kind_t      w_kind = K_DEL;
   int         w_v, w_f, w_o;
   logic [7:0] w_data;

   // Observed totals, used by the literal expectations.
   int         obs_rise = 0;
   int         obs_vcyc = 0;
   int         obs_ferr = 0;
   int         obs_ovr  = 0;
   bit         prev_valid = 1'b0;
   logic [7:0] rise_data[$];
   longint     rise_cyc[$];

   // Compare process: one pass per cycle, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_i) begin
            m_valid    = 1'b0;
            prev_valid = 1'b0;
            evq.delete();
         end else begin
            if (frame_err_o) obs_ferr++;
            if (overrun_o)   obs_ovr++;
            if (valid_o)     obs_vcyc++;
            if (valid_o && !prev_valid) begin
               obs_rise++;
               rise_data.push_back(data_o);
               rise_cyc.push_back(cyc);
            end
            prev_valid = valid_o;
            check("pulse_exclusive", 64'(frame_err_o & overrun_o), 64'd0);

            if (evq.size() != 0 && cyc + 1 >= evq[0].d) begin
               if (cyc + 1 == evq[0].d) begin
                  if (!evq[0].ok)                w_kind = K_FERR;
                  else if (m_valid && !ready_i)  w_kind = K_OVR;
                  else                           w_kind = K_DEL;
                  w_v = 0; w_f = 0; w_o = 0; w_data = 8'h00;
               end
               if (frame_err_o) w_f++;
               if (overrun_o)   w_o++;
               if (w_kind == K_DEL) begin
                  if (valid_o) begin
                     if (w_v == 0) w_data = data_o;
                     w_v++;
                  end
               end else if (m_valid) begin
                  check("win_hold_valid", 64'(valid_o), 64'd1);
                  check("win_hold_data", 64'(data_o), 64'(m_data));
               end else begin
                  check("win_no_valid", 64'(valid_o), 64'd0);
               end
               if (cyc == evq[0].d + 1) begin
                  case (w_kind)
                     K_FERR: begin
                        check("ferr_pulse", 64'(w_f), 64'd1);
                        check("ferr_no_ovr", 64'(w_o), 64'd0);
                     end
                     K_OVR: begin
                        check("ovr_pulse", 64'(w_o), 64'd1);
                        check("ovr_no_ferr", 64'(w_f), 64'd0);
                     end
                     default: begin
                        check("del_no_ferr", 64'(w_f), 64'd0);
                        check("del_no_ovr", 64'(w_o), 64'd0);
                        check("del_seen", 64'(w_v != 0), 64'd1);
                        check("del_data", 64'(w_data), 64'(evq[0].b));
                        if (ready_i) begin
                           check("del_one_cycle", 64'(w_v), 64'd1);
                           m_valid = 1'b0;
                        end else begin
                           m_valid = 1'b1;
                           m_data  = evq[0].b;
                        end
                     end
                  endcase
                  void'(evq.pop_front());
               end
            end else begin
               check("valid", 64'(valid_o), 64'(m_valid));
               if (m_valid) check("data_hold", 64'(data_o), 64'(m_data));
               check("no_ferr", 64'(frame_err_o), 64'd0);
               check("no_ovr", 64'(overrun_o), 64'd0);
            end
            // Handshake: a byte seen with ready is gone next cycle.
            if (m_valid && ready_i) m_valid = 1'b0;
         end
      end
   end

   // Drive one bit period; entered just after a rising edge.
   task automatic drive_bit(input logic v);
      #1 rx_i = v;
      repeat (C) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      ev_t e;
      #1 rx_i = 1'b0;
      e.d  = cyc + 1 + LAT;
      e.b  = b;
      e.ok = ok;
      evq.push_back(e);
      repeat (C) @(posedge clk);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(ok);
   endtask

   task automatic idle(input int n);
      #1 rx_i = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic set_ready(input logic r);
      #1 ready_i = r;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c3;
      logic [7:0] rb;
      bit         rok;
      bit         busy_seen;
      longint     dd;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_data", 64'(data_o), 64'h00);
      check("rst_busy", 64'(busy_o), 64'd1);
      check("rst_ferr", 64'(frame_err_o), 64'd0);
      check("rst_ovr", 64'(overrun_o), 64'd0);
      @(posedge clk);
      #1 reset_i = 1'b0;
      idle(20);
      @(negedge clk);
      check("idle_busy", 64'(busy_o), 64'd0);

      // Single byte with ready held high.
      @(posedge clk);
      set_ready(1'b1);
      send_byte(8'hA5, 1'b1);
      idle(20);
      @(negedge clk);
      check("a5_rises", 64'(obs_rise), 64'd1);
      check("a5_vcyc", 64'(obs_vcyc), 64'd1);
      check("a5_data", 64'(rise_data[$]), 64'hA5);
      check("a5_no_err", 64'(obs_ferr + obs_ovr), 64'd0);

      // Overrun while the holding register is full.
      @(posedge clk);
      set_ready(1'b0);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h81, 1'b1);
      idle(20);
      @(negedge clk);
      check("ovr_data_kept", 64'(data_o), 64'h3C);
      check("ovr_valid_held", 64'(valid_o), 64'd1);
      check("ovr_count", 64'(obs_ovr), 64'd1);
      check("ovr_rises", 64'(obs_rise), 64'd2);
      @(posedge clk);
      set_ready(1'b1);
      @(posedge clk);
      set_ready(1'b0);
      @(negedge clk);
      check("accept_drops_valid", 64'(valid_o), 64'd0);

      // Framing error followed by a long low line.
      @(posedge clk);
      set_ready(1'b1);
      send_byte(8'h55, 1'b0);
      for (int i = 0; i < 10; i++) begin
         repeat (10) @(posedge clk);
         @(negedge clk);
         check("ferr_busy", 64'(busy_o), 64'd1);
      end
      check("ferr_count", 64'(obs_ferr), 64'd1);
      check("ferr_no_rise", 64'(obs_rise), 64'd2);
      idle(10);
      send_byte(8'h0F, 1'b1);
      idle(20);
      @(negedge clk);
      check("0f_rises", 64'(obs_rise), 64'd3);
      check("0f_data", 64'(rise_data[$]), 64'h0F);

      // Short glitch on an idle line.
      @(posedge clk);
      busy_seen = 1'b0;
      #1 rx_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) rx_i = 1'b1;
         if (busy_o) busy_seen = 1'b1;
      end
      check("glitch_busy_seen", 64'(busy_seen), 64'd1);
      check("glitch_busy_back", 64'(busy_o), 64'd0);
      check("glitch_no_rise", 64'(obs_rise), 64'd3);
      check("glitch_no_ferr", 64'(obs_ferr), 64'd1);

      // Reset mid-frame with the line low; a pending byte is lost.
      @(posedge clk);
      set_ready(1'b0);
      send_byte(8'h11, 1'b1);
      idle(10);
      c3 = 8'hC3;
      #1 rx_i = 1'b0;
      repeat (C) @(posedge clk);
      for (int i = 0; i < 3; i++) drive_bit(c3[i]);
      #1 rx_i = c3[3];
      repeat (5) @(posedge clk);
      #1 reset_i = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 64'(valid_o), 64'd0);
      check("mid_rst_data", 64'(data_o), 64'h00);
      check("mid_rst_busy", 64'(busy_o), 64'd1);
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("low_after_rst_busy", 64'(busy_o), 64'd1);
      check("low_after_rst_rises", 64'(obs_rise), 64'd4);
      idle(20);
      set_ready(1'b1);
      send_byte(8'h5A, 1'b1);
      idle(20);
      @(negedge clk);
      check("5a_rises", 64'(obs_rise), 64'd5);
      check("5a_data", 64'(rise_data[$]), 64'h5A);

      // Back-to-back frames with no idle gap.
      @(posedge clk);
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      idle(20);
      @(negedge clk);
      check("b2b_rises", 64'(obs_rise), 64'd7);
      check("b2b_first", 64'(rise_data[$-1]), 64'h00);
      check("b2b_second", 64'(rise_data[$]), 64'hFF);
      dd = rise_cyc[$] - rise_cyc[$-1];
      check("b2b_spacing", 64'(dd >= 159 && dd <= 161), 64'd1);

      // Randomised traffic: bytes, ready level, stop bit and gaps.
      @(posedge clk);
      for (int n = 0; n < 40; n++) begin
         rb  = 8'($urandom);
         rok = ($urandom_range(0, 7) != 0);
         set_ready(1'($urandom_range(0, 1)));
         send_byte(rb, rok);
         if (rok) idle(int'($urandom_range(0, 20)));
         else     idle(int'($urandom_range(4, 20)));
      end
      idle(40);
      @(negedge clk);
      check("all_events_seen", 64'(evq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
